// File: rtl/pi_est_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pi_est_pkg
// Description : Shared types and constants for the Monte Carlo pi accumulator.
//               Provides the FSM state encoding, the batch sequence-number width,
//               and a helper that returns the fraction-bit count of the Q2 result.
// Revision    : 1.0 - initial release
// ============================================================================
package pi_est_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int SEQ_WIDTH = 8;

    // An unsigned Q2.F number of total width cnt_width has F = cnt_width - 2.
    function automatic int frac_bits(input int cnt_width);
        return cnt_width - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pi_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : pi_accum_if
// Description : Bundle of sample-side and result-side signals of pi_accum.
//               master : the accumulator (consumes samples, owns the result slot)
//               slave  : the environment (drives samples and est_ready)
//   coord_valid_in / op_lt_1_in / enable / clear : sample-side controls
//   est_valid / est_ready                        : result slot handshake
//   est_pi / est_hits / est_seq / overrun        : result payload and status
// Revision    : 1.0 - initial release
// ============================================================================
interface pi_accum_if
    import pi_est_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int BATCH_LOG2 = 20
);
    logic                  coord_valid_in;
    logic                  op_lt_1_in;
    logic                  enable;
    logic                  clear;
    logic                  est_valid;
    logic                  est_ready;
    logic [CNT_WIDTH-1:0]  est_pi;
    logic [BATCH_LOG2:0]   est_hits;
    logic [SEQ_WIDTH-1:0]  est_seq;
    logic                  overrun;

    modport master (
        input  coord_valid_in, op_lt_1_in, enable, clear, est_ready,
        output est_valid, est_pi, est_hits, est_seq, overrun
    );

    modport slave (
        output coord_valid_in, op_lt_1_in, enable, clear, est_ready,
        input  est_valid, est_pi, est_hits, est_seq, overrun
    );
endinterface
`default_nettype wire

// File: rtl/pi_scale.sv
`default_nettype none
// ============================================================================
// Module      : pi_scale
// Description : Converts a batch hit count into an unsigned Q2.(CNT_WIDTH-2)
//               pi estimate: est = 4 * h / 2^BATCH_LOG2, i.e. a left shift.
//               A full batch of hits (h = 2^BATCH_LOG2, exactly 4.0) does not fit
//               and saturates to all ones.
//   i_h      : hit count, BATCH_LOG2+1 bits
//   o_est_pi : scaled estimate, CNT_WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module pi_scale
    import pi_est_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int BATCH_LOG2 = 20
) (
    input  wire logic [BATCH_LOG2:0]  i_h,
    output wire logic [CNT_WIDTH-1:0] o_est_pi
);
    localparam int C_SHIFT = frac_bits(CNT_WIDTH) + 2 - BATCH_LOG2;

    logic [CNT_WIDTH-1:0] w_ext;
    logic [CNT_WIDTH-1:0] w_shifted;

    assign w_ext     = CNT_WIDTH'(i_h);
    assign w_shifted = w_ext << C_SHIFT;
    // The MSB of h is only set for h = 2^BATCH_LOG2, the one unrepresentable value.
    assign o_est_pi  = i_h[BATCH_LOG2] ? {CNT_WIDTH{1'b1}} : w_shifted;
endmodule
`default_nettype wire

// File: rtl/pi_accum.sv
`default_nettype none
// ============================================================================
// Module      : pi_accum
// Description : Monte Carlo pi accumulator. Counts inside-circle hits over
//               batches of 2^BATCH_LOG2 accepted samples and publishes each
//               batch as a saturated Q2 pi estimate in a valid/ready slot.
//               Sampling never stalls; an unread result that gets overwritten
//               sets the sticky overrun flag.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : pi_accum_if master view (sample inputs, result slot, status)
// Revision    : 1.0 - initial release
// ============================================================================
module pi_accum
    import pi_est_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int BATCH_LOG2 = 20
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pi_accum_if.master  bus
);
    state_t                r_state_q,      w_state_d;
    logic [BATCH_LOG2-1:0] r_sample_cnt_q, w_sample_cnt_d;
    logic [BATCH_LOG2:0]   r_hit_cnt_q,    w_hit_cnt_d;
    logic [SEQ_WIDTH-1:0]  r_seq_q,        w_seq_d;
    logic                  r_est_valid_q,  w_est_valid_d;
    logic [CNT_WIDTH-1:0]  r_est_pi_q,     w_est_pi_d;
    logic [BATCH_LOG2:0]   r_est_hits_q,   w_est_hits_d;
    logic [SEQ_WIDTH-1:0]  r_est_seq_q,    w_est_seq_d;
    logic                  r_overrun_q,    w_overrun_d;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_handshake;
    logic [BATCH_LOG2:0]   w_h;
    logic [CNT_WIDTH-1:0]  w_scaled;

    assign w_accept    = (r_state_q == ACCUM) && bus.enable && bus.coord_valid_in;
    assign w_last      = w_accept && (r_sample_cnt_q == {BATCH_LOG2{1'b1}});
    assign w_handshake = r_est_valid_q && bus.est_ready;
    // Final hit count including the sample being accepted this cycle.
    assign w_h         = r_hit_cnt_q + {{BATCH_LOG2{1'b0}}, bus.op_lt_1_in};

    pi_scale #(
        .CNT_WIDTH  (CNT_WIDTH),
        .BATCH_LOG2 (BATCH_LOG2)
    ) u_scale (
        .i_h      (w_h),
        .o_est_pi (w_scaled)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_sample_cnt_d = r_sample_cnt_q;
        w_hit_cnt_d    = r_hit_cnt_q;
        w_seq_d        = r_seq_q;
        w_est_valid_d  = r_est_valid_q;
        w_est_pi_d     = r_est_pi_q;
        w_est_hits_d   = r_est_hits_q;
        w_est_seq_d    = r_est_seq_q;
        w_overrun_d    = r_overrun_q;

        case (r_state_q)
            IDLE:    if (bus.enable)  w_state_d = ACCUM;
            ACCUM:   if (!bus.enable) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase

        if (w_last) begin
            w_sample_cnt_d = '0;
            w_hit_cnt_d    = '0;
        end else if (w_accept) begin
            w_sample_cnt_d = r_sample_cnt_q + 1'b1;
            w_hit_cnt_d    = w_h;
        end

        if (w_last) begin
            w_est_valid_d = 1'b1;
            w_est_pi_d    = w_scaled;
            w_est_hits_d  = w_h;
            w_est_seq_d   = r_seq_q;
            w_seq_d       = r_seq_q + 1'b1;
            // Only an unconsumed old result counts as lost; a same-cycle
            // handshake means the old value was taken.
            if (r_est_valid_q && !bus.est_ready) w_overrun_d = 1'b1;
        end else if (w_handshake) begin
            w_est_valid_d = 1'b0;
        end

        if (bus.clear) begin
            w_state_d      = IDLE;
            w_sample_cnt_d = '0;
            w_hit_cnt_d    = '0;
            w_seq_d        = '0;
            w_est_valid_d  = 1'b0;
            w_est_pi_d     = '0;
            w_est_hits_d   = '0;
            w_est_seq_d    = '0;
            w_overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= IDLE;
            r_sample_cnt_q <= '0;
            r_hit_cnt_q    <= '0;
            r_seq_q        <= '0;
            r_est_valid_q  <= 1'b0;
            r_est_pi_q     <= '0;
            r_est_hits_q   <= '0;
            r_est_seq_q    <= '0;
            r_overrun_q    <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_sample_cnt_q <= w_sample_cnt_d;
            r_hit_cnt_q    <= w_hit_cnt_d;
            r_seq_q        <= w_seq_d;
            r_est_valid_q  <= w_est_valid_d;
            r_est_pi_q     <= w_est_pi_d;
            r_est_hits_q   <= w_est_hits_d;
            r_est_seq_q    <= w_est_seq_d;
            r_overrun_q    <= w_overrun_d;
        end
    end

    assign bus.est_valid = r_est_valid_q;
    assign bus.est_pi    = r_est_pi_q;
    assign bus.est_hits  = r_est_hits_q;
    assign bus.est_seq   = r_est_seq_q;
    assign bus.overrun   = r_overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_pi_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_pi_accum
// Description : Self-checking bench for pi_accum with CNT_WIDTH=16, BATCH_LOG2=4.
//               Table of full batches plus hand-written overrun, same-cycle
//               handshake, enable-gap and mid-batch reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_accum;
    localparam int C_CNT_WIDTH  = 16;
    localparam int C_BATCH_LOG2 = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   exp_seq;

    pi_accum_if #(.CNT_WIDTH(C_CNT_WIDTH), .BATCH_LOG2(C_BATCH_LOG2)) bus ();

    pi_accum #(.CNT_WIDTH(C_CNT_WIDTH), .BATCH_LOG2(C_BATCH_LOG2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n_hits;
        logic [4:0]  exp_hits;
        logic [15:0] exp_pi;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // n back-to-back samples, the first nh of which are hits.
    task automatic send(input int n, input int nh);
        for (int i = 0; i < n; i++) begin
            bus.coord_valid_in = 1'b1;
            bus.op_lt_1_in     = (i < nh);
            step();
        end
        bus.coord_valid_in = 1'b0;
        bus.op_lt_1_in     = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [4:0] h, input logic [15:0] p,
                              input logic [7:0] s, input logic ov);
        chk({tag, "_valid"},   64'(bus.est_valid), 64'(1'b1));
        chk({tag, "_hits"},    64'(bus.est_hits),  64'(h));
        chk({tag, "_pi"},      64'(bus.est_pi),    64'(p));
        chk({tag, "_seq"},     64'(bus.est_seq),   64'(s));
        chk({tag, "_overrun"}, 64'(bus.overrun),   64'(ov));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},   64'(bus.est_valid), 64'(0));
        chk({tag, "_hits"},    64'(bus.est_hits),  64'(0));
        chk({tag, "_pi"},      64'(bus.est_pi),    64'(0));
        chk({tag, "_seq"},     64'(bus.est_seq),   64'(0));
        chk({tag, "_overrun"}, 64'(bus.overrun),   64'(0));
    endtask

    task automatic drain();
        bus.est_ready = 1'b1;
        step();
        bus.est_ready = 1'b0;
    endtask

    // Clear cycle, then one cycle for the IDLE->ACCUM transition (enable held high).
    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        step();
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        exp_seq = 0;
        vecs[0] = '{16, 5'd16, 16'hFFFF};
        vecs[1] = '{13, 5'd13, 16'hD000};
        vecs[2] = '{0,  5'd0,  16'h0000};
        vecs[3] = '{1,  5'd1,  16'h1000};
        vecs[4] = '{15, 5'd15, 16'hF000};
        vecs[5] = '{4,  5'd4,  16'h4000};

        rst                = 1'b1;
        bus.coord_valid_in = 1'b0;
        bus.op_lt_1_in     = 1'b0;
        bus.enable         = 1'b0;
        bus.clear          = 1'b0;
        bus.est_ready      = 1'b0;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        // First batch: 8 hits, checking latency around the final sample.
        bus.enable = 1'b1;
        step();
        send(15, 8);
        chk("latency_before_last", 64'(bus.est_valid), 64'(0));
        send(1, 0);
        chk_result("first", 5'd8, 16'h8000, 8'(exp_seq), 1'b0);
        exp_seq++;
        drain();
        chk("first_drained", 64'(bus.est_valid), 64'(0));

        for (int v = 0; v < 6; v++) begin
            send(16, vecs[v].n_hits);
            chk_result($sformatf("vec%0d", v), vecs[v].exp_hits, vecs[v].exp_pi,
                       8'(exp_seq), 1'b0);
            exp_seq++;
            drain();
            chk($sformatf("vec%0d_drained", v), 64'(bus.est_valid), 64'(0));
        end

        // Overrun: two batches with no consumer.
        do_clear();
        chk_zero("clear1");
        send(16, 2);
        send(16, 5);
        chk_result("overrun", 5'd5, 16'h5000, 8'd1, 1'b1);
        do_clear();
        chk_zero("clear2");

        // Handshake in the same cycle as the next load.
        send(16, 3);
        chk_result("hs_first", 5'd3, 16'h3000, 8'd0, 1'b0);
        send(15, 0);
        bus.est_ready = 1'b1;
        send(1, 1);
        chk_result("hs_same", 5'd1, 16'h1000, 8'd1, 1'b0);
        step();
        bus.est_ready = 1'b0;
        chk("hs_drained", 64'(bus.est_valid), 64'(0));

        // Enable gap mid-batch; the re-enable-cycle sample must be dropped.
        send(7, 4);
        bus.enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.coord_valid_in = i[0];
            bus.op_lt_1_in     = 1'b1;
            step();
        end
        chk("gap_no_result", 64'(bus.est_valid), 64'(0));
        bus.enable         = 1'b1;
        bus.coord_valid_in = 1'b1;
        bus.op_lt_1_in     = 1'b1;
        step();
        send(8, 3);
        chk("gap_before_last", 64'(bus.est_valid), 64'(0));
        send(1, 0);
        chk_result("gap", 5'd7, 16'h7000, 8'd2, 1'b0);

        // Reset mid-batch with a pending result.
        send(10, 10);
        rst = 1'b1;
        step();
        chk_zero("midreset");
        rst = 1'b0;
        step();
        send(16, 4);
        chk_result("after_reset", 5'd4, 16'h4000, 8'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
